// File: rtl/reg_pipe.sv
// ---------------------------------------------------------------------------
// reg_pipe: elastic register pipeline, WIDTH bits wide and DEPTH stages deep.
//
// Each stage carries a valid bit. Stages are linked by a valid/ready
// handshake, so an empty stage always takes the item behind it and bubbles
// collapse into a stalled tail. The ready path is a combinational ripple from
// out_ready back to in_ready, with no skid register. A synchronous flush
// drops every in-flight item, and count tracks how many items are held.
//
// Ports:
//   clk        in   1        clock, all state updates on rising edge
//   rst_n      in   1        synchronous active-low reset
//   flush      in   1        synchronous clear of all held items
//   in_valid   in   1        producer has data
//   in_ready   out  1        pipe accepts data this cycle
//   in_data    in   WIDTH    input data
//   out_valid  out  1        last stage holds an item
//   out_ready  in   1        consumer accepts
//   out_data   out  WIDTH    last-stage data
//   count      out  clog2(DEPTH+1)  items currently held, 0..DEPTH
// ---------------------------------------------------------------------------
module reg_pipe #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 3,
    parameter bit               RESET_DATA = 1'b0,
    parameter logic [WIDTH-1:0] INIT_DATA  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // rdy_s[DEPTH] is the consumer's ready, so the last stage needs no
    // special case in the ripple below.
    logic [DEPTH:0]   rdy_s;
    logic [DEPTH-1:0] move_s;
    logic [DEPTH-1:0] src_valid_s;
    logic [WIDTH-1:0] src_data_s [DEPTH];
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;

    // Ready ripple from the output stage back toward the input stage.
    always_comb begin
        rdy_s        = '0;
        move_s       = '0;
        rdy_s[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            move_s[i] = valid_q[i] & rdy_s[i+1];
            rdy_s[i]  = ~valid_q[i] | move_s[i];
        end
    end

    // Handshake outputs and push/pop strobes; flush masks both ends.
    always_comb begin
        in_ready_s  = rdy_s[0] & ~flush;
        out_valid_s = valid_q[DEPTH-1] & ~flush;
        push_s      = in_valid & in_ready_s;
        pop_s       = out_valid_s & out_ready;
    end

    // Upstream source of each stage: the input port for stage 0, otherwise
    // the previous stage.
    always_comb begin
        src_valid_s    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            src_data_s[i] = '0;
        end
        src_valid_s[0] = in_valid;
        src_data_s[0]  = in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            src_valid_s[i] = valid_q[i-1];
            src_data_s[i]  = data_q[i-1];
        end
    end

    // Next-state for valids and data; a stage loads only when it is ready.
    // Data is captured only alongside a valid item, so empty stages keep
    // stale contents.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            data_d[i] = data_q[i];
        end
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (rdy_s[i]) begin
                    valid_d[i] = src_valid_s[i];
                    if (src_valid_s[i]) begin
                        data_d[i] = src_data_s[i];
                    end else begin
                        data_d[i] = data_q[i];
                    end
                end else begin
                    valid_d[i] = valid_q[i];
                    data_d[i]  = data_q[i];
                end
            end
        end
    end

    // Occupancy next-state; a flush empties the pipe regardless of traffic.
    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Valid bits and occupancy register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    generate
        if (RESET_DATA) begin : g_data_rst
            // Data registers load INIT_DATA on reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        data_q[i] <= INIT_DATA;
                    end
                end else begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        data_q[i] <= data_d[i];
                    end
                end
            end
        end else begin : g_data_norst
            // Data registers carry no reset; they freeze while reset is
            // asserted so no handshake is honoured during reset.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        data_q[i] <= data_d[i];
                    end
                end
            end
        end
    endgenerate

    // Output assignment.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_s;
        out_data  = data_q[DEPTH-1];
        count     = count_q;
    end

endmodule

// File: tb/tb_reg_pipe.sv
module tb_reg_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready_a, out_valid_a;
    logic [7:0] out_data_a;
    logic [1:0] count_a;
    logic       in_ready_b, out_valid_b;
    logic [7:0] out_data_b;
    logic [1:0] count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1'b1), .INIT_DATA(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .count(count_a)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1'b0), .INIT_DATA(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .count(count_b)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                       input logic [1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streaming, out_ready=1: 01 appears three cycles after its in_valid.
        add(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        add(1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
        add(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2);
        add(1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 2'd3);
        add(1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 2'd3);
        add(1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 2'd3);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 2'd3);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 2'd2);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 2'd1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        // Backpressure: fill with 10..12, 13 refused while full, then drain.
        add(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
        add(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2);
        add(1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 2'd3);
        add(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 2'd3);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h12, 2'd2);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 2'd1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        // Bubble collapse with out_ready=0: 20, two idles, 21.
        add(1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
        add(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 2'd1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 2'd2);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 2'd2);
        // Fill to 3, then flush together with in_valid=1 (FF).
        add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 2'd2);
        add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd3);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);

        // Reset held for two cycles.
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("reset in_ready",  {31'd0, in_ready_a},  32'd1);
        chk("reset out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("reset count",     {30'd0, count_a},     32'd0);
        chk("reset out_data",  {24'd0, out_data_a},  32'hA5);
        chk("reset_b out_valid", {31'd0, out_valid_b}, 32'd0);
        chk("reset_b count",     {30'd0, count_b},     32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            #1;
            chk($sformatf("v%0d in_ready", i),    {31'd0, in_ready_a},  {31'd0, vecs[i].e_ir});
            chk($sformatf("v%0d out_valid", i),   {31'd0, out_valid_a}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d count", i),       {30'd0, count_a},     {30'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d b_in_ready", i),  {31'd0, in_ready_b},  {31'd0, vecs[i].e_ir});
            chk($sformatf("v%0d b_out_valid", i), {31'd0, out_valid_b}, {31'd0, vecs[i].e_ov});
            chk($sformatf("v%0d b_count", i),     {30'd0, count_b},     {30'd0, vecs[i].e_cnt});
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d out_data", i),   {24'd0, out_data_a}, {24'd0, vecs[i].e_od});
                chk($sformatf("v%0d b_out_data", i), {24'd0, out_data_b}, {24'd0, vecs[i].e_od});
            end
            tick();
        end

        // Reset mid-stream: load 30 and 31 so two items are held, 30 at the output.
        flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h30; tick();
        in_data = 8'h31; tick();
        in_valid = 1'b0; in_data = 8'h00; tick();
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("pre-reset count",     {30'd0, count_a},     32'd2);
        chk("pre-reset out_valid", {31'd0, out_valid_a}, 32'd1);
        chk("pre-reset out_data",  {24'd0, out_data_a},  32'h30);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid-reset count",       {30'd0, count_a},     32'd0);
        chk("mid-reset out_valid",   {31'd0, out_valid_a}, 32'd0);
        chk("mid-reset in_ready",    {31'd0, in_ready_a},  32'd1);
        chk("mid-reset out_data",    {24'd0, out_data_a},  32'hA5);
        chk("mid-reset b count",     {30'd0, count_b},     32'd0);
        chk("mid-reset b out_valid", {31'd0, out_valid_b}, 32'd0);
        chk("mid-reset b data held", {24'd0, out_data_b},  32'h30);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post-reset%0d out_valid", k),   {31'd0, out_valid_a}, 32'd0);
            chk($sformatf("post-reset%0d count", k),       {30'd0, count_a},     32'd0);
            chk($sformatf("post-reset%0d b_out_valid", k), {31'd0, out_valid_b}, 32'd0);
            chk($sformatf("post-reset%0d b_count", k),     {30'd0, count_b},     32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
